// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and flush controller that sits beside the fetch/decode stages of the
// pipelined RAT core. It compares decode source operands against the
// destinations of the downstream producer stages. On a hazard it either
// stalls or selects a forwarding source. It also sequences bubble runs for
// control flow, interrupt entry and reset recovery.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   src_reg/src_used     decode source operands (operand i at [i*REG_W +: REG_W])
//   dst_reg/dst_en/      producer stage destinations, write enables and
//   dst_is_load          load flags (stage 0 = EX, youngest)
//   instr_type           decode class: 1-5 branch, 6-9 return/RETI
//   branch_taken         PC load request
//   interrupt            level interrupt request
//   imem_addr_mux,       fetch hold controls (re-present PC, hold latch)
//   fetch_latch_stall
//   dec_nop              bubble into decode output
//   pc_inc/pc_load/      PC controls
//   pc_reset
//   fwd_sel              per operand: 0 = register file, s+1 = stage s
//   int_ack              single-cycle interrupt acknowledge
//   stall_count          saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
  parameter int REG_W     = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_STG   = 2,
  parameter int FWD_EN    = 0,
  parameter int FLUSH_CYC = 2,
  parameter int INT_CYC   = 2,
  parameter int RST_CYC   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SRC*REG_W-1:0]             src_reg,
  input  logic [NUM_SRC-1:0]                   src_used,
  input  logic [NUM_STG*REG_W-1:0]             dst_reg,
  input  logic [NUM_STG-1:0]                   dst_en,
  input  logic [NUM_STG-1:0]                   dst_is_load,
  input  logic [3:0]                           instr_type,
  input  logic                                 branch_taken,
  input  logic                                 interrupt,
  output logic                                 imem_addr_mux,
  output logic                                 fetch_latch_stall,
  output logic                                 dec_nop,
  output logic                                 pc_inc,
  output logic                                 pc_load,
  output logic                                 pc_reset,
  output logic [NUM_SRC*$clog2(NUM_STG+1)-1:0] fwd_sel,
  output logic                                 int_ack,
  output logic [15:0]                          stall_count
);

  localparam int SEL_W   = $clog2(NUM_STG + 1);
  localparam int CNT_MAX = (FLUSH_CYC > INT_CYC)
                         ? ((FLUSH_CYC > RST_CYC) ? FLUSH_CYC : RST_CYC)
                         : ((INT_CYC > RST_CYC) ? INT_CYC : RST_CYC);
  // cnt only ever holds reload values up to CNT_MAX-1
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] INT_LD   = CNT_W'(INT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_CHECK = 2'd0,
    S_FLUSH = 2'd1,
    S_INT   = 2'd2,
    S_RST   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_ack_q, int_ack_d;
  logic [15:0]        stall_count_q, stall_count_d;

  logic                     raw_any;
  logic                     load_use;
  logic [NUM_SRC*SEL_W-1:0] fwd_raw;
  logic                     is_ctrl;
  logic                     hazard;
  logic                     stall;

  // Only the EX-stage load flag can create a load-use stall; the others are
  // informational for the pipeline and deliberately unused here.
  logic unused_load_flags;
  assign unused_load_flags = ^dst_is_load;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Operand/producer comparison. Stages are scanned oldest to youngest so
  // the youngest matching stage is the last writer of fwd_raw.
  always_comb begin
    raw_any  = 1'b0;
    load_use = 1'b0;
    fwd_raw  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = NUM_STG - 1; s >= 0; s--) begin
        if (src_used[i] && dst_en[s] &&
            (src_reg[i*REG_W +: REG_W] == dst_reg[s*REG_W +: REG_W])) begin
          raw_any = 1'b1;
          fwd_raw[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
          if ((s == 0) && dst_is_load[0]) load_use = 1'b1;
        end
      end
    end
  end

  // Interrupt and control-flow detection outrank a data hazard in CHECK.
  always_comb begin
    is_ctrl = (instr_type >= 4'd1) && (instr_type <= 4'd9);
    hazard  = (FWD_EN != 0) ? load_use : raw_any;
    stall   = (state_q == S_CHECK) && !interrupt && !is_ctrl && hazard;
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RST;
      cnt_q         <= RST_LD;
      int_ack_q     <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      int_ack_q     <= int_ack_d;
      stall_count_q <= stall_count_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    int_ack_d     = 1'b0;
    stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
    unique case (state_q)
      S_CHECK: begin
        if (interrupt) begin
          state_d   = S_INT;
          cnt_d     = INT_LD;
          int_ack_d = 1'b1;
        end else if (is_ctrl) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LD;
        end
      end
      S_FLUSH: begin
        if (interrupt) begin
          state_d   = S_INT;
          cnt_d     = INT_LD;
          int_ack_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_INT, S_RST: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
  end

  // ---- output logic ----
  always_comb begin
    imem_addr_mux     = 1'b0;
    fetch_latch_stall = 1'b0;
    dec_nop           = 1'b0;
    pc_reset          = 1'b0;
    fwd_sel           = '0;
    unique case (state_q)
      S_CHECK: begin
        dec_nop           = interrupt | is_ctrl | stall;
        fetch_latch_stall = stall;
        imem_addr_mux     = stall;
        fwd_sel           = (FWD_EN != 0) ? fwd_raw : '0;
      end
      S_FLUSH, S_INT: dec_nop = 1'b1;
      S_RST: begin
        pc_reset = 1'b1;
        dec_nop  = 1'b1;
      end
    endcase
    pc_load = branch_taken & ~pc_reset;
    pc_inc  = ~pc_reset & ~pc_load & ~stall;
  end

  assign int_ack     = int_ack_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// Bench for pipeline_hazard_unit. Two instances share all inputs: one with
// stall-only hazard handling, one with forwarding. A mode/bubbles-left model
// predicts every output each cycle; directed scenarios run first, then
// randomized traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

  localparam int REG_W     = 5;
  localparam int NUM_SRC   = 2;
  localparam int NUM_STG   = 2;
  localparam int FLUSH_CYC = 2;
  localparam int INT_CYC   = 2;
  localparam int RST_CYC   = 2;
  localparam int SEL_W     = $clog2(NUM_STG + 1);

  localparam int M_NORM = 0, M_FLUSH = 1, M_INT = 2, M_RST = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_SRC*REG_W-1:0] src_reg;
  logic [NUM_SRC-1:0]       src_used;
  logic [NUM_STG*REG_W-1:0] dst_reg;
  logic [NUM_STG-1:0]       dst_en;
  logic [NUM_STG-1:0]       dst_is_load;
  logic [3:0]               instr_type;
  logic                     branch_taken;
  logic                     interrupt;

  logic imem_addr_mux_0, fetch_latch_stall_0, dec_nop_0, pc_inc_0, pc_load_0, pc_reset_0, int_ack_0;
  logic imem_addr_mux_1, fetch_latch_stall_1, dec_nop_1, pc_inc_1, pc_load_1, pc_reset_1, int_ack_1;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_0, fwd_sel_1;
  logic [15:0]              stall_count_0, stall_count_1;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .FWD_EN(0),
    .FLUSH_CYC(FLUSH_CYC), .INT_CYC(INT_CYC), .RST_CYC(RST_CYC)
  ) dut0 (
    .clk(clk), .reset(reset), .src_reg(src_reg), .src_used(src_used),
    .dst_reg(dst_reg), .dst_en(dst_en), .dst_is_load(dst_is_load),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .imem_addr_mux(imem_addr_mux_0), .fetch_latch_stall(fetch_latch_stall_0),
    .dec_nop(dec_nop_0), .pc_inc(pc_inc_0), .pc_load(pc_load_0), .pc_reset(pc_reset_0),
    .fwd_sel(fwd_sel_0), .int_ack(int_ack_0), .stall_count(stall_count_0)
  );

  pipeline_hazard_unit #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .FWD_EN(1),
    .FLUSH_CYC(FLUSH_CYC), .INT_CYC(INT_CYC), .RST_CYC(RST_CYC)
  ) dut1 (
    .clk(clk), .reset(reset), .src_reg(src_reg), .src_used(src_used),
    .dst_reg(dst_reg), .dst_en(dst_en), .dst_is_load(dst_is_load),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .imem_addr_mux(imem_addr_mux_1), .fetch_latch_stall(fetch_latch_stall_1),
    .dec_nop(dec_nop_1), .pc_inc(pc_inc_1), .pc_load(pc_load_1), .pc_reset(pc_reset_1),
    .fwd_sel(fwd_sel_1), .int_ack(int_ack_1), .stall_count(stall_count_1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: current mode, bubble cycles left in it, expected ack,
  // expected stall counts for each instance.
  int m_mode;
  int m_left;
  bit m_ack;
  int m_scnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit match(input int i, input int s);
    return src_used[i] && dst_en[s] &&
           (src_reg[i*REG_W +: REG_W] == dst_reg[s*REG_W +: REG_W]);
  endfunction

  function automatic bit any_match();
    for (int i = 0; i < NUM_SRC; i++)
      for (int s = 0; s < NUM_STG; s++)
        if (match(i, s)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ex_load_match();
    for (int i = 0; i < NUM_SRC; i++)
      if (match(i, 0) && dst_is_load[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] nearest_fwd();
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int sel;
      sel = 0;
      for (int s = 0; s < NUM_STG; s++)
        if (sel == 0 && match(i, s)) sel = s + 1;
      res[i*SEL_W +: SEL_W] = SEL_W'(sel);
    end
    return res;
  endfunction

  function automatic bit is_ctrl_type();
    return (instr_type >= 4'd1) && (instr_type <= 4'd9);
  endfunction

  task automatic check_now(input string tag);
    bit norm, in_rst, ld;
    bit st[2];
    logic [6:0] exp_v[2];
    norm   = (m_mode == M_NORM);
    in_rst = (m_mode == M_RST);
    st[0]  = norm && !interrupt && !is_ctrl_type() && any_match();
    st[1]  = norm && !interrupt && !is_ctrl_type() && ex_load_match();
    ld     = branch_taken && !in_rst;
    for (int k = 0; k < 2; k++)
      exp_v[k] = {st[k], st[k], (!norm || interrupt || is_ctrl_type() || st[k]),
                  (!in_rst && !ld && !st[k]), ld, in_rst, m_ack};
    chk({tag, ":ctl0"}, {25'd0, imem_addr_mux_0, fetch_latch_stall_0, dec_nop_0,
                          pc_inc_0, pc_load_0, pc_reset_0, int_ack_0}, {25'd0, exp_v[0]});
    chk({tag, ":ctl1"}, {25'd0, imem_addr_mux_1, fetch_latch_stall_1, dec_nop_1,
                          pc_inc_1, pc_load_1, pc_reset_1, int_ack_1}, {25'd0, exp_v[1]});
    chk({tag, ":cnt0"}, 32'(stall_count_0), 32'(m_scnt[0]));
    chk({tag, ":cnt1"}, 32'(stall_count_1), 32'(m_scnt[1]));
    if (norm || in_rst) begin
      chk({tag, ":fwd0"}, 32'(fwd_sel_0), 32'd0);
      chk({tag, ":fwd1"}, 32'(fwd_sel_1), norm ? nearest_fwd() : 32'd0);
    end
  endtask

  task automatic model_edge();
    bit ctrl, norm;
    if (!reset) begin
      m_mode = M_RST; m_left = RST_CYC; m_ack = 1'b0;
      m_scnt[0] = 0; m_scnt[1] = 0;
      return;
    end
    ctrl = is_ctrl_type();
    norm = (m_mode == M_NORM);
    if (norm && !interrupt && !ctrl && any_match() && m_scnt[0] < 65535) m_scnt[0]++;
    if (norm && !interrupt && !ctrl && ex_load_match() && m_scnt[1] < 65535) m_scnt[1]++;
    m_ack = 1'b0;
    if ((norm || m_mode == M_FLUSH) && interrupt) begin
      m_mode = M_INT; m_left = INT_CYC; m_ack = 1'b1;
    end else if (norm) begin
      if (ctrl) begin m_mode = M_FLUSH; m_left = FLUSH_CYC; end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = M_NORM;
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are checked just
  // after the falling edge; the model advances on the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    #1;
    check_now(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_now(input string tag);
    reset = 1'b0;
    m_mode = M_RST; m_left = RST_CYC; m_ack = 1'b0;
    m_scnt[0] = 0; m_scnt[1] = 0;
    #1;
    check_now(tag);
  endtask

  task automatic idle();
    src_reg = '0; src_used = '0; dst_reg = '0; dst_en = '0; dst_is_load = '0;
    instr_type = 4'd0; branch_taken = 1'b0; interrupt = 1'b0;
  endtask

  task automatic set_src(input int i, input int r);
    src_reg[i*REG_W +: REG_W] = REG_W'(r);
  endtask

  task automatic set_dst(input int s, input int r);
    dst_reg[s*REG_W +: REG_W] = REG_W'(r);
  endtask

  initial begin
    int rst_hold;
    idle();
    reset = 1'b1;
    m_mode = M_NORM; m_left = 0; m_ack = 1'b0; m_scnt[0] = 0; m_scnt[1] = 0;
    #1;
    reset_now("rst_async");
    repeat (3) cycle("rst_low");
    reset = 1'b1;
    repeat (2) cycle("rst_recover");
    cycle("first_check");

    // RAW on operand 0 vs EX for two cycles
    set_src(0, 5); src_used = 2'b01; set_dst(0, 5); dst_en = 2'b01;
    repeat (2) cycle("raw_stall");
    idle();
    cycle("raw_clear");
    chk("stall_count_fwd_off", 32'(stall_count_0), 32'd2);
    chk("stall_count_fwd_on", 32'(stall_count_1), 32'd0);

    // Forwarding selection and load-use
    set_src(0, 3); src_used = 2'b01; set_dst(0, 3); set_dst(1, 3); dst_en = 2'b11;
    #1;
    chk("fwd_nearest", 32'(fwd_sel_1), 32'd1);
    cycle("fwd_both");
    dst_is_load = 2'b01;
    #1;
    chk("load_use_stall", 32'(fetch_latch_stall_1), 32'd1);
    cycle("load_use");
    dst_is_load = 2'b00; dst_en = 2'b10; set_src(1, 3); src_used = 2'b11;
    cycle("fwd_stage1");
    dst_is_load = 2'b10; dst_en = 2'b11; set_dst(0, 9);
    cycle("load_stage1");
    idle();
    cycle("fwd_clear");

    // Branch flush with a concurrent hazard
    set_src(0, 7); src_used = 2'b01; set_dst(0, 7); dst_en = 2'b01; dst_is_load = 2'b01;
    instr_type = 4'd4;
    cycle("flush_detect");
    instr_type = 4'd2;
    repeat (2) cycle("flush_run");
    instr_type = 4'd0;
    cycle("flush_exit");
    idle();
    cycle("flush_idle");

    // Interrupt preempting the second flush cycle
    instr_type = 4'd8;
    cycle("pre_detect");
    instr_type = 4'd0;
    cycle("pre_flush1");
    interrupt = 1'b1;
    cycle("pre_flush2_int");
    interrupt = 1'b0;
    repeat (2) cycle("pre_int");
    cycle("pre_exit");

    // Interrupt and control together, then branch during a stall
    interrupt = 1'b1; instr_type = 4'd7;
    cycle("int_ctrl_detect");
    interrupt = 1'b0; instr_type = 4'd0;
    repeat (3) cycle("int_ctrl_after");
    set_src(1, 12); src_used = 2'b10; set_dst(1, 12); dst_en = 2'b10; branch_taken = 1'b1;
    cycle("branch_stall");
    instr_type = 4'd15;
    cycle("type15_not_ctrl");
    idle();

    // Reset landing in the first INT cycle
    interrupt = 1'b1;
    cycle("int_detect");
    interrupt = 1'b0;
    reset_now("rst_in_int");
    chk("rst_in_int_ack", 32'(int_ack_1), 32'd0);
    cycle("rst_in_int_low");
    reset = 1'b1;
    repeat (3) cycle("rst_in_int_recover");

    // Randomized traffic
    rst_hold = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_SRC; i++) set_src(i, $urandom_range(0, 3));
      for (int s = 0; s < NUM_STG; s++) set_dst(s, $urandom_range(0, 3));
      src_used     = NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1));
      dst_en       = NUM_STG'($urandom_range(0, (1 << NUM_STG) - 1));
      dst_is_load  = NUM_STG'($urandom_range(0, (1 << NUM_STG) - 1));
      instr_type   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      branch_taken = ($urandom_range(0, 3) == 0);
      interrupt    = ($urandom_range(0, 11) == 0);
      if (!reset) begin
        if (rst_hold == 0) reset = 1'b1;
        else rst_hold--;
      end else if ($urandom_range(0, 60) == 0) begin
        reset_now("rand_rst");
        rst_hold = $urandom_range(0, 2);
      end
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
